alu_mux_arbiter: RTL and testbench

ALU_MUX_ARBITER -- requirements
Module: alu_mux_arbiter

---
 rtl/alu_arb_pkg.sv | 21 ++
 rtl/rr_pick4.sv | 38 +++
 rtl/alu_mux_arbiter.sv | 80 ++++++++
 tb/tb_alu_mux_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the 4-way result-mux arbiter.
// Purely combinational definitions; no latency, no flow control.
package alu_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int CNT_W         = 4;
  localparam int OP_CYCLES_DEF = 2;

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (oh[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational one-hot round-robin picker, scan 3->2->1->0 from one below last; zero latency, no backpressure.
// With ALU_ARB_FIXED_PRIO_EN defined, bit 3 always wins and bits 2..0 rotate among themselves.
module rr_pick4
  import alu_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic [1:0] last,
  output logic [3:0] win
);

  logic [3:0] cand;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    cand  = req & ~mask;
    win   = 4'b0000;
    idx   = 2'd0;
    found = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (cand[3]) begin
      win   = 4'b1000;
      found = 1'b1;
    end
    cand[3] = 1'b0;
`endif
    // Descending index with 2-bit wrap gives the 3->2->1->0->3 rotation.
    for (int k = 1; k <= 4; k++) begin
      idx = last - 2'(k);
      if (!found && cand[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_mux_arbiter.sv
// alu_mux_arbiter: grants one of four requesters the result mux for OP_CYCLES cycles; sel one cycle after req, back-to-back regrant.
// No backpressure: requester holds req until its done pulse. Option ALU_ARB_FIXED_PRIO_EN makes req[3] always win.
module alu_mux_arbiter
  import alu_arb_pkg::*;
#(
  parameter int OP_CYCLES = OP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] sel,
  output logic [3:0] done,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OP_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       sel_nxt, done_nxt, mask, win;
  logic [1:0]       last, last_nxt;
  logic             busy_nxt;
  logic             arb;

  // Finishing requester is masked so a held req cannot regrant itself.
  assign mask = (state == BUSY) ? sel : 4'b0000;
  assign arb  = (state == IDLE) || (cnt == '0);

  rr_pick4 u_pick (
    .req  (req),
    .mask (mask),
    .last (last),
    .win  (win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= 4'b0000;
      done  <= 4'b0000;
      busy  <= 1'b0;
      last  <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sel   <= sel_nxt;
      done  <= done_nxt;
      busy  <= busy_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (arb)
      state_nxt = (win != 4'b0000) ? BUSY : IDLE;
  end

  always_comb begin
    sel_nxt  = sel;
    cnt_nxt  = cnt;
    last_nxt = last;
    if (arb) begin
      sel_nxt = win;
      cnt_nxt = (win != 4'b0000) ? CNT_LOAD : '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
      if (win != 4'b0000 && !win[3])
`else
      if (win != 4'b0000)
`endif
        last_nxt = onehot_idx(win);
    end else begin
      cnt_nxt = cnt - CNT_W'(1);
    end
    done_nxt = (sel_nxt != 4'b0000 && cnt_nxt == '0) ? sel_nxt : 4'b0000;
    busy_nxt = (sel_nxt != 4'b0000);
  end

endmodule

// File: tb/tb_alu_mux_arbiter.sv
// Bench for alu_mux_arbiter: three instances (OP_CYCLES 2, 1, 3) against a grant/remaining-cycles reference model.
module tb_alu_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rq [3];
  logic [3:0] s  [3];
  logic [3:0] d  [3];
  logic       b  [3];

  int checks = 0;
  int errors = 0;

  int op     [3] = '{2, 1, 3};
  int m_g    [3];
  int m_rem  [3];
  int m_last [3];

  always #5 clk = ~clk;

  alu_mux_arbiter #(.OP_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .req(rq[0]), .sel(s[0]), .done(d[0]), .busy(b[0]));
  alu_mux_arbiter #(.OP_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .req(rq[1]), .sel(s[1]), .done(d[1]), .busy(b[1]));
  alu_mux_arbiter #(.OP_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .req(rq[2]), .sel(s[2]), .done(d[2]), .busy(b[2]));

  // Model: m_g = granted requester index (-1 idle), m_rem = selected cycles left including the current one.
  function automatic int pick(input logic [3:0] c, input int last);
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (c[3]) return 3;
`endif
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (last + 4 - k) % 4;
`ifdef ALU_ARB_FIXED_PRIO_EN
      if (idx == 3) continue;
`endif
      if (((c >> idx) & 4'b0001) != 4'b0000) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_sel(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return (m_g[i] >= 0) ? (one << m_g[i]) : 4'b0000;
  endfunction

  function automatic logic [3:0] exp_done(input int i);
    return (m_rem[i] == 1) ? exp_sel(i) : 4'b0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_g[i] = -1; m_rem[i] = 0; m_last[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (m_rem[i] > 1) begin
        m_rem[i]--;
      end else begin
        logic [3:0] cand;
        int w;
        cand = rq[i] & ~exp_sel(i);
        w = pick(cand, m_last[i]);
        if (w >= 0) begin
          m_g[i] = w; m_rem[i] = op[i];
`ifdef ALU_ARB_FIXED_PRIO_EN
          if (w != 3) m_last[i] = w;
`else
          m_last[i] = w;
`endif
        end else begin
          m_g[i] = -1; m_rem[i] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) rq[i] = 4'b0000;
    model_reset();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) rq[i] = 4'b0000;
    model_reset();
    tick();
    for (int i = 0; i < 3; i++) rq[i] = 4'b1111;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (s[i] !== 4'b0000 || d[i] !== 4'b0000 || b[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset inst%0d: sel=%b done=%b busy=%b expected 0000 0000 0", i, s[i], d[i], b[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] es [4];
    logic [3:0] ed [4];
    es = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
    ed = '{4'b0000, 4'b0100, 4'b0000, 4'b0000};
    do_reset();
    rq[0] = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (s[0] !== es[c] || d[0] !== ed[c] || b[0] !== (es[c] != 4'b0000)) begin
        errors++;
        $display("FAIL single c%0d: sel=%b done=%b busy=%b expected %b %b %b", c, s[0], d[0], b[0], es[c], ed[c], es[c] != 4'b0000);
      end
      if (c == 1) rq[0] = 4'b0000;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g [5];
    logic [3:0] ed;
    g = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    do_reset();
    rq[0] = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      ed = (c % 2 == 1) ? g[c/2] : 4'b0000;
      checks++;
      if (s[0] !== g[c/2] || d[0] !== ed || b[0] !== 1'b1) begin
        errors++;
        $display("FAIL round_robin c%0d: sel=%b done=%b busy=%b expected %b %b 1", c, s[0], d[0], b[0], g[c/2], ed);
      end
    end
    rq[0] = 4'b0000;
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    rq[0] = 4'b0010;
    tick();
    checks++;
    if (s[0] !== 4'b0010) begin
      errors++;
      $display("FAIL mid_reset_pre: sel=%b expected 0010", s[0]);
    end
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (s[0] !== 4'b0000 || d[0] !== 4'b0000 || b[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: sel=%b done=%b busy=%b expected 0000 0000 0", s[0], d[0], b[0]);
    end
    rq[0] = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (s[0] !== 4'b0000 || d[0] !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_after: sel=%b done=%b expected 0000 0000", s[0], d[0]);
    end
    // Pointer must be back at "bit 3 first" after reset.
    rq[0] = 4'b1001;
    tick();
    checks++;
    if (s[0] !== 4'b1000) begin
      errors++;
      $display("FAIL mid_reset_ptr: sel=%b expected 1000", s[0]);
    end
  endtask

  task automatic test_op1();
    logic [3:0] es [3];
    es = '{4'b0010, 4'b0001, 4'b0000};
    do_reset();
    rq[1] = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (s[1] !== es[c] || d[1] !== es[c]) begin
        errors++;
        $display("FAIL op1 c%0d: sel=%b done=%b expected both %b", c, s[1], d[1], es[c]);
      end
      if (c == 1) rq[1] = 4'b0001;
    end
    rq[1] = 4'b0000;
  endtask

  task automatic test_fixed_prio();
    logic [3:0] g [4];
`ifdef ALU_ARB_FIXED_PRIO_EN
    g = '{4'b1000, 4'b0010, 4'b1000, 4'b0001};
`else
    g = '{4'b1000, 4'b0010, 4'b0001, 4'b1000};
`endif
    do_reset();
    rq[0] = 4'b1011;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (s[0] !== g[c/2]) begin
        errors++;
        $display("FAIL prio_order c%0d: sel=%b expected %b", c, s[0], g[c/2]);
      end
    end
  endtask

  task automatic test_drop_mid();
    logic [3:0] es [4];
    logic [3:0] ed [4];
    es = '{4'b0100, 4'b0100, 4'b0100, 4'b0000};
    ed = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};
    do_reset();
    rq[2] = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      rq[2] = 4'b0000;
      checks++;
      if (s[2] !== es[c] || d[2] !== ed[c]) begin
        errors++;
        $display("FAIL drop_mid c%0d: sel=%b done=%b expected %b %b", c, s[2], d[2], es[c], ed[c]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 2) == 0) rq[i] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (s[i] !== exp_sel(i) || d[i] !== exp_done(i) || b[i] !== (exp_sel(i) != 4'b0000)) begin
          errors++;
          $display("FAIL random n%0d inst%0d: sel=%b done=%b busy=%b expected %b %b %b",
                   n, i, s[i], d[i], b[i], exp_sel(i), exp_done(i), exp_sel(i) != 4'b0000);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) rq[i] = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_mid_reset();
    test_op1();
    test_fixed_prio();
    test_drop_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
